// File: rtl/spad_pkg.sv
// Shared constants, read-status encoding and modulo pointer helper for the
// ifmap sliding-window scratch pad.
package spad_pkg;

  localparam int unsigned SPAD_DW    = 16;
  localparam int unsigned SPAD_DEPTH = 12;

  // Status of the read issued in the previous cycle.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_OK   = 2'd1,
    RD_ERR  = 2'd2
  } rd_status_e;

  // Modulo-depth add for pointers. Both operands must already be < depth,
  // so a single conditional subtract is enough (no general modulo).
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned amt,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + amt;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage

// File: rtl/spad_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
module spad_mem
  import spad_pkg::*;
#(
  parameter  int unsigned DW    = SPAD_DW,
  parameter  int unsigned DEPTH = SPAD_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage write; contents are intentionally left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read; output only changes on an enabled read.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ifmap_spad_win.sv
// Circular sliding-window ifmap scratch pad: streamed writes at the tail,
// head-relative reads with 1-cycle latency, and a multi-entry shift that
// retires the oldest entries. Optional macro IFMAP_SPAD_WIN_FWD_EN forwards
// the entry being written to a same-cycle read at offset == count.
//
// Handshake: a write transfers on a cycle where wr_valid && wr_ready; wr_valid
// while full is dropped silently. Reads and shifts are single-cycle commands
// with no back-pressure. All commands in one cycle see the pre-update state.
module ifmap_spad_win
  import spad_pkg::*;
#(
  parameter  int unsigned DW    = SPAD_DW,
  parameter  int unsigned DEPTH = SPAD_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  input  logic          shift_en,
  input  logic [AW:0]   shift_amt,
  output logic          shift_err,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  rd_status_e    rd_status_q, rd_status_d;
  logic          shift_err_q, shift_err_d;
  logic [DW-1:0] rd_hold_q, rd_hold_d;

  logic          w_acc;
  logic          rd_ok;
  logic          fwd_hit;
  logic [AW:0]   s_eff;
  logic [AW-1:0] rd_phys;
  logic [DW-1:0] mem_rdata;

`ifdef IFMAP_SPAD_WIN_FWD_EN
  logic          fwd_q, fwd_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;
`endif

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign count    = count_q;

  // Command decode, pointer/count update and read status, all from pre-update state.
  always_comb begin
    w_acc   = wr_valid && !full;
    rd_ok   = rd_en && ({1'b0, rd_addr} < count_q);
    fwd_hit = 1'b0;
`ifdef IFMAP_SPAD_WIN_FWD_EN
    fwd_hit = rd_en && w_acc && ({1'b0, rd_addr} == count_q);
`endif
    s_eff = '0;
    if (shift_en) s_eff = (shift_amt > count_q) ? count_q : shift_amt;
    shift_err_d = shift_en && (shift_amt > count_q);

    rd_phys = AW'(wrap_add(32'(head_q), 32'(rd_addr), DEPTH));
    head_d  = AW'(wrap_add(32'(head_q), 32'(s_eff), DEPTH));
    tail_d  = w_acc ? AW'(wrap_add(32'(tail_q), 32'd1, DEPTH)) : tail_q;
    count_d = count_q + {{AW{1'b0}}, w_acc} - s_eff;

    rd_status_d = RD_IDLE;
    if (rd_en) rd_status_d = (rd_ok || fwd_hit) ? RD_OK : RD_ERR;

`ifdef IFMAP_SPAD_WIN_FWD_EN
    fwd_d      = fwd_hit;
    fwd_data_d = fwd_hit ? wr_data : fwd_data_q;
`endif
  end

  // Output data mux: fresh data on a good read, otherwise the held value.
  always_comb begin
    rd_data = rd_hold_q;
    if (rd_status_q == RD_OK) rd_data = mem_rdata;
`ifdef IFMAP_SPAD_WIN_FWD_EN
    if (rd_status_q == RD_OK && fwd_q) rd_data = fwd_data_q;
`endif
    rd_hold_d = rd_data;
  end

  assign rd_valid  = (rd_status_q == RD_OK);
  assign rd_err    = (rd_status_q == RD_ERR);
  assign shift_err = shift_err_q;

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_status_q <= RD_IDLE;
      shift_err_q <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_status_q <= rd_status_d;
      shift_err_q <= shift_err_d;
      rd_hold_q   <= rd_hold_d;
    end
  end

`ifdef IFMAP_SPAD_WIN_FWD_EN
  // Forwarding capture for a read of the entry being written this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`endif

  spad_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (w_acc),
    .waddr (tail_q),
    .wdata (wr_data),
    .re    (rd_ok),
    .raddr (rd_phys),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ifmap_spad_win.sv
// Directed bench for ifmap_spad_win: driver tasks push expected read results
// into a queue, a negedge monitor pops and compares them.
module tb_ifmap_spad_win;

  localparam int DW = 16;
  localparam int DEPTH = 12;
  localparam int AW = 4;

  logic          clk;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          shift_en;
  logic [AW:0]   shift_amt;
  logic          shift_err;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  // Expected read response: {err, data}
  logic [DW:0]   exp_q[$];
  int            n_cmp;
  int            n_bad;
  logic [DW-1:0] last_data;

  ifmap_spad_win dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .shift_en  (shift_en),
    .shift_amt (shift_amt),
    .shift_err (shift_err),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int addr, input bit ok, input logic [DW-1:0] d);
    if (ok) begin
      exp_q.push_back({1'b0, d});
      last_data = d;
    end else begin
      exp_q.push_back({1'b1, last_data});
    end
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic do_shift(input int amt);
    shift_en  = 1'b1;
    shift_amt = (AW+1)'(amt);
    tick();
    shift_en  = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && (rd_valid || rd_err)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: valid=%0b err=%0b data=0x%0h, none expected",
                 rd_valid, rd_err, rd_data);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (rd_err !== e[DW] || rd_valid !== !e[DW] || rd_data !== e[DW-1:0]) begin
          n_bad++;
          $display("FAIL read_resp: got valid=%0b err=%0b data=0x%0h expected err=%0b data=0x%0h",
                   rd_valid, rd_err, rd_data, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0; last_data = '0;
    reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; shift_en = 1'b0; shift_amt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_err", int'(rd_err), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_shift_err", int'(shift_err), 0);
    reset_n = 1'b1;
    tick();

    // Fill to full
    for (int i = 0; i < DEPTH; i++) do_write(DW'(16'h0011 + i));
    check("fill_count", int'(count), 12);
    check("fill_full", int'(full), 1);
    check("fill_wr_ready", int'(wr_ready), 0);
    check("fill_empty", int'(empty), 0);
    do_write(16'hDEAD);
    check("overfill_count", int'(count), 12);

    // Reads from full state
    do_read(0, 1'b1, 16'h0011);
    do_read(5, 1'b1, 16'h0016);
    do_read(11, 1'b1, 16'h001C);
    do_read(12, 1'b0, 16'h0000);
    tick();

    // Shift 3, refill with wrap
    do_shift(3);
    check("shift3_count", int'(count), 9);
    check("shift3_err", int'(shift_err), 0);
    do_write(16'h0101);
    do_write(16'h0102);
    do_write(16'h0103);
    check("wrap_count", int'(count), 12);
    do_read(0, 1'b1, 16'h0014);
    do_read(11, 1'b1, 16'h0103);

    // Down to 4, then over-shift with a same-cycle write
    do_shift(8);
    check("shift8_count", int'(count), 4);
    shift_en = 1'b1; shift_amt = 5'd7;
    wr_valid = 1'b1; wr_data = 16'h0BEE;
    tick();
    shift_en = 1'b0; wr_valid = 1'b0;
    check("clamp_shift_err", int'(shift_err), 1);
    check("clamp_count", int'(count), 1);
    do_read(0, 1'b1, 16'h0BEE);
    check("shift_err_pulse_end", int'(shift_err), 0);

    // Write plus read at offset == count
    wr_valid = 1'b1; wr_data = 16'h0A0A;
`ifdef IFMAP_SPAD_WIN_FWD_EN
    do_read(1, 1'b1, 16'h0A0A);
`else
    do_read(1, 1'b0, 16'h0000);
`endif
    wr_valid = 1'b0;
    check("fwd_count", int'(count), 2);

    // Zero shift is a no-op; full drain then an empty read
    do_shift(0);
    check("shift0_count", int'(count), 2);
    check("shift0_err", int'(shift_err), 0);
    do_shift(2);
    check("drain_empty", int'(empty), 1);
    do_read(0, 1'b0, 16'h0000);
    tick();

    // Build count = 6, then reset with a read in flight
    for (int i = 0; i < 6; i++) do_write(DW'(16'h0C01 + i));
    check("pre_rst_count", int'(count), 6);
    rd_en = 1'b1; rd_addr = 4'd0;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_rd_valid", int'(rd_valid), 0);
    check("mid_rst_rd_data", int'(rd_data), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
